fpu_ss_issue_scoreboard: RTL and testbench
==========================================

// Module: fpu_ss_issue_scoreboard
// PURPOSE
//  Parametrised issue-gating scoreboard for the FPU subsystem. Sits between the input buffer pop port and
//  the FPnew/LSU paths. Tracks per-FPR pending-write counts, committed instruction IDs and the in-flight count.
//  Asserts issue_ready_o only when operands are hazard-free or forwardable and the instruction ID is committed.
//  Extends the single-bit rd scoreboard with: multi-write (WAW) counting, dual writeback ports,
//  an in-order mode and an outstanding-instruction limit.
// PARAMETERS
//  NUM_REGS     32  number of FP registers tracked; RW = $clog2(NUM_REGS)
//  ID_WIDTH     4   instruction ID width; at most 2**ID_WIDTH - 1 instructions in flight
//  PEND_WIDTH   2   per-register pending-write counter width; saturates at 2**PEND_WIDTH - 1
//  ALLOW_WAW    0   1: issue may target an rd with pending writes; 0: stall unless that write retires this cycle
//  FORWARDING   1   1: a writeback this cycle satisfies a matching source operand
//  OUT_OF_ORDER 1   0: issue only when in-flight count is 0, or is 1 and an FPU writeback occurs this cycle
// PORTS
//  clk_i           in   1         clock
//  rst_ni          in   1         synchronous active-low reset
//  commit_valid_i  in   1         commit strobe from core
//  commit_id_i     in   ID_WIDTH  committed/killed ID
//  commit_kill_i   in   1         1: kill (ID never marked committed)
//  issue_valid_i   in   1         head of input buffer valid
//  issue_ready_o   out  1         issue accepted; fire = valid & ready
//  issue_id_i      in   ID_WIDTH  ID of head instruction
//  issue_lsu_i     in   1         1: memory instruction (no commit check), 0: FPnew instruction
//  issue_rs_i      in   3*RW      source regs rs1/rs2/rs3, [RW-1:0] = rs1
//  issue_rs_used_i in   3         per-source FP-register operand enable
//  issue_rd_i      in   RW        destination FPR
//  issue_rd_we_i   in   1         instruction writes an FPR
//  wb_fpu_valid_i  in   1         FPnew output handshake fires
//  wb_fpu_id_i     in   ID_WIDTH  ID of FPnew result
//  wb_fpu_we_i     in   1         FPnew result writes an FPR
//  wb_fpu_rd_i     in   RW        FPnew result destination
//  wb_lsu_valid_i  in   1         memory result valid (all loads and stores)
//  wb_lsu_we_i     in   1         memory result writes an FPR (load)
//  wb_lsu_rd_i     in   RW        load destination
//  fwd_fpu_o       out  3         per-source select of FPnew result
//  fwd_lsu_o       out  3         per-source select of load result
//  inflight_o      out  ID_WIDTH  issued, not yet written back
//  busy_o          out  1         inflight_o != 0 or any pending counter != 0
// BEHAVIOUR
//  Reset: all pend counters 0, commit bitmap 0, inflight 0; outputs low (issue_ready_o comb, low with valid=0).
//  pend[r]: +1 on issue fire with rd_we (rd = r); -1 per writeback with we (rd = r), FPU and LSU each count;
//   all same-cycle events on one register net out (e.g. +1 -1 -1 => -1). Counter never wraps.
//  rs k hazard: rs_used[k] & pend[rs k] != 0 & ~fwd_k. Forwarding only when pend == 1 and a matching writeback
//   with we is active; FPU takes priority over LSU if both match. fwd_*_o are 0 when FORWARDING=0,
//   and are qualified by issue_valid_i.
//  rd hazard (issue_rd_we_i):
//   pend[rd] == max, unless a writeback to rd is active this cycle;
//   ALLOW_WAW=0: pend[rd] != 0, unless pend[rd] == 1 and a writeback to rd is active this cycle.
//  Commit bitmap: set bit on commit_valid & ~kill; clear bit wb_fpu_id_i on wb_fpu_valid_i (clear wins if same ID).
//   A non-LSU instruction needs bit[issue_id_i] set, or a same-cycle unkilled commit of issue_id_i.
//  issue_ready_o = issue_valid_i & no rs hazard & no rd hazard & commit ok & inflight limit ok & order ok.
//   Inflight limit ok: inflight_o < 2**ID_WIDTH - 1, or a writeback is active this cycle.
//  inflight: +1 on fire, -1 per wb_fpu_valid_i and per wb_lsu_valid_i (net, max -2/+1 per cycle).
//   Underflow is an assertion failure.
//  Reset mid-operation: all state clears on the next edge; in-flight results arriving afterwards are the
//   caller's problem (FPnew is flushed on the same reset).
//  Latency: zero-cycle combinational issue decision; state updates one edge after the event.
// TESTING
//  1. Issue ID 3 fadd rd=f5 with no commit -> ready=0; commit id 3 same cycle -> ready=1; bit 3 set after edge, cleared on wb.
//  2. f5 pend=1, issue fmul rs1=f5 while FPU wb rd=f5 we -> fwd_fpu_o=3'b001, ready=1; pend[5] nets to 0.
//  3. ALLOW_WAW=1, PEND_WIDTH=2: three issues to rd=f7 -> pend=3; fourth stalls until wb rd=f7, then fires same cycle.
//  4. FPU wb rd=f2 and LSU wb rd=f2 together with pend[2]=2 -> pend[2]=0; inflight -2.
//  5. OUT_OF_ORDER=0: inflight=1, second instr held until wb_fpu_valid_i=1; hold 1 cycle -> issue on wb cycle.
//  6. ID_WIDTH=2: 3 in flight -> ready=0; assert rst_ni=0 for one edge -> inflight_o=0, busy_o=0.

Source files
------------

// File: rtl/fpu_ss_issue_scoreboard.sv
// Issue-gating scoreboard for the FPU subsystem: per-FPR pending-write
// counters, committed-ID bitmap and in-flight limit with optional forwarding.
module fpu_ss_issue_scoreboard #(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned ID_WIDTH     = 4,
  parameter int unsigned PEND_WIDTH   = 2,
  parameter bit          ALLOW_WAW    = 1'b0,
  parameter bit          FORWARDING   = 1'b1,
  parameter bit          OUT_OF_ORDER = 1'b1,
  localparam int unsigned RW          = $clog2(NUM_REGS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic                issue_lsu_i,
  input  logic [3*RW-1:0]     issue_rs_i,
  input  logic [2:0]          issue_rs_used_i,
  input  logic [RW-1:0]       issue_rd_i,
  input  logic                issue_rd_we_i,
  input  logic                wb_fpu_valid_i,
  input  logic [ID_WIDTH-1:0] wb_fpu_id_i,
  input  logic                wb_fpu_we_i,
  input  logic [RW-1:0]       wb_fpu_rd_i,
  input  logic                wb_lsu_valid_i,
  input  logic                wb_lsu_we_i,
  input  logic [RW-1:0]       wb_lsu_rd_i,
  output logic [2:0]          fwd_fpu_o,
  output logic [2:0]          fwd_lsu_o,
  output logic [ID_WIDTH-1:0] inflight_o,
  output logic                busy_o
);

  localparam int unsigned NID = 2 ** ID_WIDTH;
  localparam logic [PEND_WIDTH-1:0] PMAX = '1;
  localparam logic [ID_WIDTH-1:0] IMAX = '1;

  logic [PEND_WIDTH-1:0] pend_q [NUM_REGS];
  logic [PEND_WIDTH-1:0] pend_d [NUM_REGS];
  logic [NID-1:0]        cmt_q;
  logic [NID-1:0]        cmt_d;
  logic [ID_WIDTH-1:0]   inflight_q;
  logic [ID_WIDTH-1:0]   inflight_d;

  logic            fpu_wr;
  logic            lsu_wr;
  logic            wb_any;
  logic [2:0]      rs_haz;
  logic [2:0]      fwd_fpu;
  logic [2:0]      fwd_lsu;
  logic [RW-1:0]   rs;
  logic            fm;
  logic            lm;
  logic            one;
  logic [PEND_WIDTH-1:0] rd_p;
  logic            rd_wb;
  logic            rd_haz;
  logic            commit_ok;
  logic            limit_ok;
  logic            order_ok;
  logic            fire;
  logic            any_pend;

  assign fpu_wr = wb_fpu_valid_i & wb_fpu_we_i;
  assign lsu_wr = wb_lsu_valid_i & wb_lsu_we_i;
  assign wb_any = wb_fpu_valid_i | wb_lsu_valid_i;

  // Forwarding only resolves the last outstanding write to a source.
  always_comb begin
    rs_haz  = '0;
    fwd_fpu = '0;
    fwd_lsu = '0;
    rs      = '0;
    fm      = 1'b0;
    lm      = 1'b0;
    one     = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rs  = issue_rs_i[k*RW +: RW];
      fm  = fpu_wr && (wb_fpu_rd_i == rs);
      lm  = lsu_wr && (wb_lsu_rd_i == rs);
      one = (pend_q[rs] == PEND_WIDTH'(1));
      fwd_fpu[k] = FORWARDING && issue_rs_used_i[k] && one && fm;
      fwd_lsu[k] = FORWARDING && issue_rs_used_i[k] && one && lm && !fm;
      rs_haz[k]  = issue_rs_used_i[k] && (pend_q[rs] != '0)
                   && !fwd_fpu[k] && !fwd_lsu[k];
    end
  end

  assign fwd_fpu_o = fwd_fpu & {3{issue_valid_i}};
  assign fwd_lsu_o = fwd_lsu & {3{issue_valid_i}};

  assign rd_p   = pend_q[issue_rd_i];
  assign rd_wb  = (fpu_wr && (wb_fpu_rd_i == issue_rd_i))
               || (lsu_wr && (wb_lsu_rd_i == issue_rd_i));
  assign rd_haz = issue_rd_we_i
               && (((rd_p == PMAX) && !rd_wb)
               || (!ALLOW_WAW && (rd_p != '0)
                   && !((rd_p == PEND_WIDTH'(1)) && rd_wb)));

  assign commit_ok = issue_lsu_i || cmt_q[issue_id_i]
                  || (commit_valid_i && !commit_kill_i
                      && (commit_id_i == issue_id_i));
  assign limit_ok  = (inflight_q != IMAX) || wb_any;
  assign order_ok  = OUT_OF_ORDER || (inflight_q == '0)
                  || ((inflight_q == ID_WIDTH'(1)) && wb_fpu_valid_i);

  assign issue_ready_o = issue_valid_i && (rs_haz == '0) && !rd_haz
                      && commit_ok && limit_ok && order_ok;
  assign fire = issue_ready_o;

  // Same-cycle events net out; the result is clamped instead of wrapping.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      int n;
      n = int'(pend_q[r])
        + int'(fire && issue_rd_we_i && (issue_rd_i == RW'(r)))
        - int'(fpu_wr && (wb_fpu_rd_i == RW'(r)))
        - int'(lsu_wr && (wb_lsu_rd_i == RW'(r)));
      if (n < 0)
        pend_d[r] = '0;
      else if (n > int'(PMAX))
        pend_d[r] = PMAX;
      else
        pend_d[r] = PEND_WIDTH'(n);
    end
  end

  always_comb begin
    cmt_d = cmt_q;
    for (int i = 0; i < NID; i++) begin
      if (commit_valid_i && !commit_kill_i && (commit_id_i == ID_WIDTH'(i)))
        cmt_d[i] = 1'b1;
      if (wb_fpu_valid_i && (wb_fpu_id_i == ID_WIDTH'(i)))
        cmt_d[i] = 1'b0;
    end
  end

  always_comb begin
    int n;
    n = int'(inflight_q) + int'(fire)
      - int'(wb_fpu_valid_i) - int'(wb_lsu_valid_i);
    inflight_d = ID_WIDTH'(n);
  end

  always_comb begin
    any_pend = 1'b0;
    for (int r = 0; r < NUM_REGS; r++)
      any_pend = any_pend | (pend_q[r] != '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_q     <= '{default: '0};
      cmt_q      <= '0;
      inflight_q <= '0;
    end else begin
      pend_q     <= pend_d;
      cmt_q      <= cmt_d;
      inflight_q <= inflight_d;
    end
  end

  assign inflight_o = inflight_q;
  assign busy_o     = (inflight_q != '0) || any_pend;

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (int'(inflight_q) + int'(fire))
      >= (int'(wb_fpu_valid_i) + int'(wb_lsu_valid_i)));

endmodule

// File: tb/tb_fpu_ss_issue_scoreboard.sv
// Directed bench for the issue scoreboard: two instances cover
// WAW/out-of-order/forwarding variants and the small-ID limit case.
module tb_fpu_ss_issue_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [3:0]  commit_id;
  logic        commit_kill;
  logic [3:0]  issue_id;
  logic        issue_lsu;
  logic [14:0] issue_rs;
  logic [2:0]  issue_rs_used;
  logic [4:0]  issue_rd;
  logic        issue_rd_we;
  logic [3:0]  wb_fpu_id;
  logic        wb_fpu_we;
  logic [4:0]  wb_fpu_rd;
  logic        wb_lsu_we;
  logic [4:0]  wb_lsu_rd;

  logic        a_commit_v, a_issue_v, a_fpu_v, a_lsu_v;
  logic        a_ready, a_busy;
  logic [2:0]  a_fwd_fpu, a_fwd_lsu;
  logic [1:0]  a_infl;

  logic        b_commit_v, b_issue_v, b_fpu_v, b_lsu_v;
  logic        b_ready, b_busy;
  logic [2:0]  b_fwd_fpu, b_fwd_lsu;
  logic [3:0]  b_infl;

  int errors;
  int checks;

  fpu_ss_issue_scoreboard #(
    .NUM_REGS(32), .ID_WIDTH(2), .PEND_WIDTH(2),
    .ALLOW_WAW(1'b1), .FORWARDING(1'b1), .OUT_OF_ORDER(1'b1)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .commit_valid_i(a_commit_v), .commit_id_i(commit_id[1:0]),
    .commit_kill_i(commit_kill),
    .issue_valid_i(a_issue_v), .issue_ready_o(a_ready),
    .issue_id_i(issue_id[1:0]), .issue_lsu_i(issue_lsu),
    .issue_rs_i(issue_rs), .issue_rs_used_i(issue_rs_used),
    .issue_rd_i(issue_rd), .issue_rd_we_i(issue_rd_we),
    .wb_fpu_valid_i(a_fpu_v), .wb_fpu_id_i(wb_fpu_id[1:0]),
    .wb_fpu_we_i(wb_fpu_we), .wb_fpu_rd_i(wb_fpu_rd),
    .wb_lsu_valid_i(a_lsu_v), .wb_lsu_we_i(wb_lsu_we),
    .wb_lsu_rd_i(wb_lsu_rd),
    .fwd_fpu_o(a_fwd_fpu), .fwd_lsu_o(a_fwd_lsu),
    .inflight_o(a_infl), .busy_o(a_busy)
  );

  fpu_ss_issue_scoreboard #(
    .NUM_REGS(32), .ID_WIDTH(4), .PEND_WIDTH(2),
    .ALLOW_WAW(1'b0), .FORWARDING(1'b0), .OUT_OF_ORDER(1'b0)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .commit_valid_i(b_commit_v), .commit_id_i(commit_id),
    .commit_kill_i(commit_kill),
    .issue_valid_i(b_issue_v), .issue_ready_o(b_ready),
    .issue_id_i(issue_id), .issue_lsu_i(issue_lsu),
    .issue_rs_i(issue_rs), .issue_rs_used_i(issue_rs_used),
    .issue_rd_i(issue_rd), .issue_rd_we_i(issue_rd_we),
    .wb_fpu_valid_i(b_fpu_v), .wb_fpu_id_i(wb_fpu_id),
    .wb_fpu_we_i(wb_fpu_we), .wb_fpu_rd_i(wb_fpu_rd),
    .wb_lsu_valid_i(b_lsu_v), .wb_lsu_we_i(wb_lsu_we),
    .wb_lsu_rd_i(wb_lsu_rd),
    .fwd_fpu_o(b_fwd_fpu), .fwd_lsu_o(b_fwd_lsu),
    .inflight_o(b_infl), .busy_o(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    commit_id = '0; commit_kill = 1'b0;
    issue_id = '0; issue_lsu = 1'b0;
    issue_rs = '0; issue_rs_used = '0;
    issue_rd = '0; issue_rd_we = 1'b0;
    wb_fpu_id = '0; wb_fpu_we = 1'b0; wb_fpu_rd = '0;
    wb_lsu_we = 1'b0; wb_lsu_rd = '0;
    a_commit_v = 1'b0; a_issue_v = 1'b0;
    a_fpu_v = 1'b0; a_lsu_v = 1'b0;
    b_commit_v = 1'b0; b_issue_v = 1'b0;
    b_fpu_v = 1'b0; b_lsu_v = 1'b0;
  endtask

  task automatic set_rs(input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] r3, input logic [2:0] used);
    issue_rs = {r3, r2, r1};
    issue_rs_used = used;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr();
    tick();
    tick();
    checks++; if (a_ready !== 1'b0) begin errors++;
      $display("FAIL rst_ready: got %b want 0", a_ready); end
    checks++; if (a_infl !== 2'd0) begin errors++;
      $display("FAIL rst_inflight: got %0d want 0", a_infl); end
    checks++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin errors++;
      $display("FAIL rst_busy: got %b%b want 00", a_busy, b_busy); end
    checks++; if (a_fwd_fpu !== 3'b000 || a_fwd_lsu !== 3'b000) begin errors++;
      $display("FAIL rst_fwd: got %b/%b want 000/000", a_fwd_fpu, a_fwd_lsu); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_commit_fwd();
    clr();
    a_issue_v = 1'b1; issue_id = 4'd3; issue_rd = 5'd5; issue_rd_we = 1'b1;
    #1;
    checks++; if (a_ready !== 1'b0) begin errors++;
      $display("FAIL commit_none_ready: got %b want 0", a_ready); end
    a_commit_v = 1'b1; commit_id = 4'd3;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++;
      $display("FAIL commit_same_cycle_ready: got %b want 1", a_ready); end
    tick();
    clr();
    #1;
    checks++; if (a_infl !== 2'd1 || a_busy !== 1'b1) begin errors++;
      $display("FAIL commit_state: got infl=%0d busy=%b want 1/1", a_infl, a_busy); end
    a_issue_v = 1'b1; issue_id = 4'd3;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++;
      $display("FAIL commit_bit_set: got %b want 1", a_ready); end
    issue_id = 4'd2; a_commit_v = 1'b1; commit_id = 4'd2; commit_kill = 1'b1;
    #1;
    checks++; if (a_ready !== 1'b0) begin errors++;
      $display("FAIL commit_kill: got %b want 0", a_ready); end
    clr();
    a_issue_v = 1'b1; issue_lsu = 1'b1; set_rs(5'd5, 5'd0, 5'd0, 3'b001);
    #1;
    checks++; if (a_ready !== 1'b0 || a_fwd_fpu !== 3'b000) begin errors++;
      $display("FAIL raw_stall: got ready=%b fwd=%b want 0/000", a_ready, a_fwd_fpu); end
    issue_lsu = 1'b0; issue_id = 4'd0; issue_rd = 5'd6; issue_rd_we = 1'b1;
    a_commit_v = 1'b1; commit_id = 4'd0;
    a_fpu_v = 1'b1; wb_fpu_id = 4'd3; wb_fpu_we = 1'b1; wb_fpu_rd = 5'd5;
    #1;
    checks++; if (a_fwd_fpu !== 3'b001 || a_fwd_lsu !== 3'b000) begin errors++;
      $display("FAIL fwd_fpu_sel: got %b/%b want 001/000", a_fwd_fpu, a_fwd_lsu); end
    checks++; if (a_ready !== 1'b1) begin errors++;
      $display("FAIL fwd_fpu_ready: got %b want 1", a_ready); end
    tick();
    clr();
    #1;
    checks++; if (a_infl !== 2'd1) begin errors++;
      $display("FAIL fwd_inflight: got %0d want 1", a_infl); end
    a_issue_v = 1'b1; issue_lsu = 1'b1; set_rs(5'd5, 5'd0, 5'd0, 3'b001);
    #1;
    checks++; if (a_ready !== 1'b1 || a_fwd_fpu !== 3'b000) begin errors++;
      $display("FAIL pend5_cleared: got ready=%b fwd=%b want 1/000", a_ready, a_fwd_fpu); end
    clr();
    a_issue_v = 1'b1; issue_id = 4'd3;
    #1;
    checks++; if (a_ready !== 1'b0) begin errors++;
      $display("FAIL commit_bit_cleared: got %b want 0", a_ready); end
    clr();
    a_fpu_v = 1'b1; wb_fpu_id = 4'd0; wb_fpu_we = 1'b1; wb_fpu_rd = 5'd6;
    tick();
    clr();
    #1;
    checks++; if (a_infl !== 2'd0 || a_busy !== 1'b0) begin errors++;
      $display("FAIL commit_drain: got infl=%0d busy=%b want 0/0", a_infl, a_busy); end
  endtask

  task automatic test_in_order();
    clr();
    b_issue_v = 1'b1; issue_id = 4'd1; issue_rd = 5'd1; issue_rd_we = 1'b1;
    b_commit_v = 1'b1; commit_id = 4'd1;
    #1;
    checks++; if (b_ready !== 1'b1) begin errors++;
      $display("FAIL order_first: got %b want 1", b_ready); end
    tick();
    clr();
    b_issue_v = 1'b1; issue_lsu = 1'b1; issue_id = 4'd2;
    issue_rd = 5'd8; issue_rd_we = 1'b1;
    #1;
    checks++; if (b_ready !== 1'b0) begin errors++;
      $display("FAIL order_hold: got %b want 0", b_ready); end
    tick();
    checks++; if (b_ready !== 1'b0 || b_infl !== 4'd1) begin errors++;
      $display("FAIL order_hold2: got ready=%b infl=%0d want 0/1", b_ready, b_infl); end
    b_fpu_v = 1'b1; wb_fpu_id = 4'd1; wb_fpu_we = 1'b1; wb_fpu_rd = 5'd1;
    #1;
    checks++; if (b_ready !== 1'b1) begin errors++;
      $display("FAIL order_wb_cycle: got %b want 1", b_ready); end
    tick();
    clr();
    #1;
    checks++; if (b_infl !== 4'd1) begin errors++;
      $display("FAIL order_inflight: got %0d want 1", b_infl); end
    b_issue_v = 1'b1; issue_lsu = 1'b1; set_rs(5'd8, 5'd0, 5'd0, 3'b001);
    b_fpu_v = 1'b1; wb_fpu_id = 4'd2; wb_fpu_we = 1'b1; wb_fpu_rd = 5'd8;
    #1;
    checks++; if (b_ready !== 1'b0 || b_fwd_fpu !== 3'b000) begin errors++;
      $display("FAIL nofwd_stall: got ready=%b fwd=%b want 0/000", b_ready, b_fwd_fpu); end
    b_issue_v = 1'b0;
    tick();
    clr();
    b_issue_v = 1'b1; issue_lsu = 1'b1; set_rs(5'd8, 5'd0, 5'd0, 3'b001);
    #1;
    checks++; if (b_ready !== 1'b1 || b_busy !== 1'b0) begin errors++;
      $display("FAIL nofwd_after: got ready=%b busy=%b want 1/0", b_ready, b_busy); end
    clr();
    b_issue_v = 1'b1; issue_lsu = 1'b1; issue_rd = 5'd9; issue_rd_we = 1'b1;
    tick();
    b_fpu_v = 1'b1;
    #1;
    checks++; if (b_ready !== 1'b0) begin errors++;
      $display("FAIL waw_stall: got %b want 0", b_ready); end
    wb_fpu_we = 1'b1; wb_fpu_rd = 5'd9;
    #1;
    checks++; if (b_ready !== 1'b1) begin errors++;
      $display("FAIL waw_retire: got %b want 1", b_ready); end
    tick();
    clr();
    b_fpu_v = 1'b1; wb_fpu_we = 1'b1; wb_fpu_rd = 5'd9;
    tick();
    clr();
    #1;
    checks++; if (b_infl !== 4'd0 || b_busy !== 1'b0) begin errors++;
      $display("FAIL order_drain: got infl=%0d busy=%b want 0/0", b_infl, b_busy); end
  endtask

  task automatic test_dual_wb();
    clr();
    a_issue_v = 1'b1; issue_lsu = 1'b1; issue_rd = 5'd2; issue_rd_we = 1'b1;
    tick();
    tick();
    clr();
    #1;
    checks++; if (a_infl !== 2'd2) begin errors++;
      $display("FAIL dual_setup: got %0d want 2", a_infl); end
    a_issue_v = 1'b1; issue_lsu = 1'b1; set_rs(5'd2, 5'd0, 5'd0, 3'b001);
    a_fpu_v = 1'b1; wb_fpu_we = 1'b1; wb_fpu_rd = 5'd2;
    a_lsu_v = 1'b1; wb_lsu_we = 1'b1; wb_lsu_rd = 5'd2;
    #1;
    checks++; if (a_ready !== 1'b0 || a_fwd_fpu !== 3'b000 || a_fwd_lsu !== 3'b000) begin errors++;
      $display("FAIL dual_nofwd_pend2: got ready=%b fwd=%b/%b want 0/000/000", a_ready, a_fwd_fpu, a_fwd_lsu); end
    a_issue_v = 1'b0;
    tick();
    clr();
    #1;
    checks++; if (a_infl !== 2'd0 || a_busy !== 1'b0) begin errors++;
      $display("FAIL dual_net: got infl=%0d busy=%b want 0/0", a_infl, a_busy); end
    a_issue_v = 1'b1; issue_lsu = 1'b1; issue_rd = 5'd3; issue_rd_we = 1'b1;
    tick();
    clr();
    a_issue_v = 1'b1; issue_lsu = 1'b1; set_rs(5'd0, 5'd3, 5'd0, 3'b010);
    a_lsu_v = 1'b1; wb_lsu_we = 1'b1; wb_lsu_rd = 5'd3;
    #1;
    checks++; if (a_ready !== 1'b1 || a_fwd_lsu !== 3'b010 || a_fwd_fpu !== 3'b000) begin errors++;
      $display("FAIL fwd_lsu: got ready=%b fwd=%b/%b want 1/000/010", a_ready, a_fwd_fpu, a_fwd_lsu); end
    tick();
    clr();
    a_issue_v = 1'b1; issue_lsu = 1'b1; issue_rd = 5'd3; issue_rd_we = 1'b1;
    tick();
    clr();
    a_issue_v = 1'b1; issue_lsu = 1'b1; set_rs(5'd0, 5'd0, 5'd3, 3'b100);
    a_fpu_v = 1'b1; wb_fpu_we = 1'b1; wb_fpu_rd = 5'd3;
    a_lsu_v = 1'b1; wb_lsu_we = 1'b1; wb_lsu_rd = 5'd3;
    #1;
    checks++; if (a_ready !== 1'b1 || a_fwd_fpu !== 3'b100 || a_fwd_lsu !== 3'b000) begin errors++;
      $display("FAIL fwd_priority: got ready=%b fwd=%b/%b want 1/100/000", a_ready, a_fwd_fpu, a_fwd_lsu); end
    tick();
    clr();
    #1;
    checks++; if (a_infl !== 2'd1) begin errors++;
      $display("FAIL fwd_priority_infl: got %0d want 1", a_infl); end
    a_fpu_v = 1'b1;
    tick();
    clr();
    #1;
    checks++; if (a_infl !== 2'd0 || a_busy !== 1'b0) begin errors++;
      $display("FAIL pend_no_wrap: got infl=%0d busy=%b want 0/0", a_infl, a_busy); end
  endtask

  task automatic test_waw_limit_reset();
    clr();
    a_issue_v = 1'b1; issue_lsu = 1'b1; issue_rd = 5'd7; issue_rd_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (a_ready !== 1'b1) begin errors++;
        $display("FAIL waw_issue%0d: got %b want 1", i, a_ready); end
      tick();
    end
    checks++; if (a_ready !== 1'b0 || a_infl !== 2'd3) begin errors++;
      $display("FAIL waw_max_stall: got ready=%b infl=%0d want 0/3", a_ready, a_infl); end
    a_fpu_v = 1'b1; wb_fpu_we = 1'b1; wb_fpu_rd = 5'd7;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++;
      $display("FAIL waw_max_retire: got %b want 1", a_ready); end
    tick();
    clr();
    a_issue_v = 1'b1; issue_lsu = 1'b1;
    #1;
    checks++; if (a_ready !== 1'b0 || a_infl !== 2'd3 || a_busy !== 1'b1) begin errors++;
      $display("FAIL limit_stall: got ready=%b infl=%0d busy=%b want 0/3/1", a_ready, a_infl, a_busy); end
    a_issue_v = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++; if (a_infl !== 2'd0 || a_busy !== 1'b0) begin errors++;
      $display("FAIL midreset: got infl=%0d busy=%b want 0/0", a_infl, a_busy); end
    rst_n = 1'b1;
    a_issue_v = 1'b1; issue_lsu = 1'b1; issue_rd = 5'd7; issue_rd_we = 1'b1;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++;
      $display("FAIL midreset_pend: got %b want 1", a_ready); end
    clr();
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_commit_fwd();
    test_in_order();
    test_dual_wb();
    test_waw_limit_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
